motor_fault_ctrl: RTL and testbench

Per-channel overcurrent supervisor and enable sequencer for the two H-bridge motor channels (A/B). It turns the top-level run requests and the driver's OCA/OCB overcurrent flags into the bridge enables ENA/ENB. Behaviour covers debounced tripping, a timed cool-down, bounded automatic retries and a latched lockout that only an explicit clear releases. It sits between the top-level state machine (run_a/run_b, clear) and the motor driver pins.

---
 rtl/motor_pkg.sv | 18 +
 rtl/motor_fault_chan.sv | 126 ++++++++++++
 rtl/motor_fault_ctrl.sv | 91 +++++++++
 tb/tb_motor_fault_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared state encoding and default parameters for the motor fault supervisor
package motor_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_COOL = 2'd2,
      ST_LOCK = 2'd3
   } motor_state_e;

   localparam int COOL_CYCLES_DEF = 50_000_000;
   localparam int COOL_W_DEF      = 26;
   localparam int DEB_CYCLES_DEF  = 4;
   localparam int MAX_RETRY_DEF   = 3;
   localparam int RETRY_W_DEF     = 2;
   localparam int LINKED_DEF      = 1;

endpackage

// File: rtl/motor_fault_chan.sv
// rtl/motor_fault_chan.sv - one channel: debounce, cool-down, retry counting and lockout FSM
module motor_fault_chan
   import motor_pkg::*;
#(
   parameter int COOL_CYCLES = COOL_CYCLES_DEF,
   parameter int COOL_W      = COOL_W_DEF,
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int MAX_RETRY   = MAX_RETRY_DEF,
   parameter int RETRY_W     = RETRY_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ocs_i,
   input  logic               run_i,
   input  logic               clear_i,
   input  logic               force_cool_i,
   output logic               trip_o,
   output logic               en_o,
   output logic               fault_o,
   output logic               lock_o,
   output logic [RETRY_W-1:0] retry_o
);

   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [COOL_W-1:0]  COOL_LAST = COOL_W'(COOL_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   motor_state_e       state_q, state_d;
   logic [DEB_W-1:0]   deb_q, deb_d;
   logic [COOL_W-1:0]  cool_q, cool_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [RETRY_W-1:0] retry_inc;
   logic               en_q, fault_q, lock_q;

   // Trip fires on the edge where the debounce count would reach DEB_CYCLES.
   assign trip_o    = (state_q == ST_RUN) && ocs_i && (deb_q == DEB_LAST);
   assign retry_inc = (&retry_q) ? retry_q : retry_q + RETRY_W'(1);

   // Next-state, counter and retry bookkeeping; the cool counter doubles as the
   // retry-decay timer while running.
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      cool_d  = cool_q;
      retry_d = retry_q;
      case (state_q)
         ST_OFF: begin
            deb_d  = '0;
            cool_d = '0;
            if (force_cool_i) state_d = ST_COOL;
            else if (run_i)   state_d = ST_RUN;
         end
         ST_RUN: begin
            if (trip_o) begin
               state_d = ST_COOL;
               retry_d = retry_inc;
               cool_d  = '0;
               deb_d   = '0;
            end else if (force_cool_i) begin
               state_d = ST_COOL;
               cool_d  = '0;
               deb_d   = '0;
            end else if (!run_i) begin
               state_d = ST_OFF;
               cool_d  = '0;
               deb_d   = '0;
            end else begin
               deb_d = ocs_i ? deb_q + DEB_W'(1) : '0;
               if (cool_q == COOL_LAST) retry_d = '0;
               else                     cool_d  = cool_q + COOL_W'(1);
            end
         end
         ST_COOL: begin
            deb_d = '0;
            if (force_cool_i) begin
               cool_d = '0;
            end else if (cool_q == COOL_LAST) begin
               cool_d = '0;
               if (retry_q == RETRY_MAX) state_d = ST_LOCK;
               else if (ocs_i)           retry_d = retry_inc;
               else if (run_i)           state_d = ST_RUN;
               else                      state_d = ST_OFF;
            end else begin
               cool_d = cool_q + COOL_W'(1);
            end
         end
         ST_LOCK: begin
            deb_d  = '0;
            cool_d = '0;
            if (clear_i && !ocs_i) begin
               state_d = ST_OFF;
               retry_d = '0;
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

   // State, counters and registered pin outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_OFF;
         deb_q   <= '0;
         cool_q  <= '0;
         retry_q <= '0;
         en_q    <= 1'b0;
         fault_q <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         cool_q  <= cool_d;
         retry_q <= retry_d;
         en_q    <= (state_d == ST_RUN);
         fault_q <= (state_d == ST_COOL) || (state_d == ST_LOCK);
         lock_q  <= (state_d == ST_LOCK);
      end
   end

   assign en_o    = en_q;
   assign fault_o = fault_q;
   assign lock_o  = lock_q;
   assign retry_o = retry_q;

endmodule

// File: rtl/motor_fault_ctrl.sv
// rtl/motor_fault_ctrl.sv - two-channel H-bridge overcurrent supervisor and enable sequencer
module motor_fault_ctrl
   import motor_pkg::*;
#(
   parameter int COOL_CYCLES = COOL_CYCLES_DEF,
   parameter int COOL_W      = COOL_W_DEF,
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int MAX_RETRY   = MAX_RETRY_DEF,
   parameter int RETRY_W     = RETRY_W_DEF,
   parameter int LINKED      = LINKED_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               OCA,
   input  logic               OCB,
   input  logic               run_a,
   input  logic               run_b,
   input  logic               clear,
   output logic               ENA,
   output logic               ENB,
   output logic               fault_a,
   output logic               fault_b,
   output logic               lock_a,
   output logic               lock_b,
   output logic [RETRY_W-1:0] retry_a,
   output logic [RETRY_W-1:0] retry_b
);

   logic oca_s1_q, oca_s2_q, ocb_s1_q, ocb_s2_q;
   logic trip_a, trip_b, force_a, force_b;

   // Two-flop synchronizers for the asynchronous driver overcurrent flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         oca_s1_q <= 1'b0;
         oca_s2_q <= 1'b0;
         ocb_s1_q <= 1'b0;
         ocb_s2_q <= 1'b0;
      end else begin
         oca_s1_q <= OCA;
         oca_s2_q <= oca_s1_q;
         ocb_s1_q <= OCB;
         ocb_s2_q <= ocb_s1_q;
      end
   end

   // A trip on one bridge pulls the other into cool-down when the channels are linked.
   assign force_a = (LINKED != 0) && trip_b;
   assign force_b = (LINKED != 0) && trip_a;

   motor_fault_chan #(
      .COOL_CYCLES (COOL_CYCLES),
      .COOL_W      (COOL_W),
      .DEB_CYCLES  (DEB_CYCLES),
      .MAX_RETRY   (MAX_RETRY),
      .RETRY_W     (RETRY_W)
   ) u_chan_a (
      .clk          (clk),
      .reset        (reset),
      .ocs_i        (oca_s2_q),
      .run_i        (run_a),
      .clear_i      (clear),
      .force_cool_i (force_a),
      .trip_o       (trip_a),
      .en_o         (ENA),
      .fault_o      (fault_a),
      .lock_o       (lock_a),
      .retry_o      (retry_a)
   );

   motor_fault_chan #(
      .COOL_CYCLES (COOL_CYCLES),
      .COOL_W      (COOL_W),
      .DEB_CYCLES  (DEB_CYCLES),
      .MAX_RETRY   (MAX_RETRY),
      .RETRY_W     (RETRY_W)
   ) u_chan_b (
      .clk          (clk),
      .reset        (reset),
      .ocs_i        (ocb_s2_q),
      .run_i        (run_b),
      .clear_i      (clear),
      .force_cool_i (force_b),
      .trip_o       (trip_b),
      .en_o         (ENB),
      .fault_o      (fault_b),
      .lock_o       (lock_b),
      .retry_o      (retry_b)
   );

endmodule

// File: tb/tb_motor_fault_ctrl.sv
// tb/tb_motor_fault_ctrl.sv - scoreboard bench for motor_fault_ctrl
module tb_motor_fault_ctrl;

   logic       clk = 1'b0;
   logic       reset, OCA, OCB, run_a, run_b, clear;
   logic       ENA, ENB, fault_a, fault_b, lock_a, lock_b;
   logic [1:0] retry_a, retry_b;

   string      exp_name_q[$];
   logic [9:0] exp_val_q[$];
   string      e_name;
   logic [9:0] e_val;
   logic [9:0] act;
   int         total = 0;
   int         bad = 0;

   motor_fault_ctrl #(
      .COOL_CYCLES (8),
      .COOL_W      (4),
      .DEB_CYCLES  (2),
      .MAX_RETRY   (2),
      .RETRY_W     (2),
      .LINKED      (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .OCA     (OCA),
      .OCB     (OCB),
      .run_a   (run_a),
      .run_b   (run_b),
      .clear   (clear),
      .ENA     (ENA),
      .ENB     (ENB),
      .fault_a (fault_a),
      .fault_b (fault_b),
      .lock_a  (lock_a),
      .lock_b  (lock_b),
      .retry_a (retry_a),
      .retry_b (retry_b)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected value fields: ENA ENB fault_a fault_b lock_a lock_b retry_a retry_b
   task automatic expect_out(input string name, input logic ena, input logic enb,
                             input logic fa, input logic fb, input logic la, input logic lb,
                             input logic [1:0] ra, input logic [1:0] rb);
      exp_name_q.push_back(name);
      exp_val_q.push_back({ena, enb, fa, fb, la, lb, ra, rb});
   endtask

   // Monitor: compares every pending expectation against the outputs mid-cycle.
   always @(negedge clk) begin
      while (exp_val_q.size() > 0) begin
         e_val  = exp_val_q.pop_front();
         e_name = exp_name_q.pop_front();
         act    = {ENA, ENB, fault_a, fault_b, lock_a, lock_b, retry_a, retry_b};
         total  = total + 1;
         if (act !== e_val) begin
            bad = bad + 1;
            $display("FAIL %s: got %b expected %b (ENA ENB fa fb la lb ra rb)", e_name, act, e_val);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; OCA = 1'b0; OCB = 1'b0; run_a = 1'b0; run_b = 1'b0; clear = 1'b0;
      step(2);
      expect_out("reset", 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      reset = 1'b0;
      step(1);
      expect_out("idle", 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      run_a = 1'b1; run_b = 1'b1;
      step(1);
      expect_out("run_on", 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);

      OCA = 1'b1;
      step(1);
      OCA = 1'b0;
      step(5);
      expect_out("glitch", 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);

      OCA = 1'b1;
      step(2);
      OCA = 1'b0;
      step(1);
      expect_out("pre_trip", 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
      step(1);
      expect_out("trip", 0, 0, 1, 1, 0, 0, 2'd1, 2'd0);
      step(7);
      expect_out("cool_end", 0, 0, 1, 1, 0, 0, 2'd1, 2'd0);
      step(1);
      expect_out("recover", 1, 1, 0, 0, 0, 0, 2'd1, 2'd0);
      step(7);
      expect_out("pre_decay", 1, 1, 0, 0, 0, 0, 2'd1, 2'd0);
      step(1);
      expect_out("decay", 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);

      OCA = 1'b1;
      step(4);
      expect_out("trip2", 0, 0, 1, 1, 0, 0, 2'd1, 2'd0);
      step(8);
      expect_out("restart", 0, 1, 1, 0, 0, 0, 2'd2, 2'd0);
      step(7);
      expect_out("pre_lock", 0, 1, 1, 0, 0, 0, 2'd2, 2'd0);
      step(1);
      expect_out("lock", 0, 1, 1, 0, 1, 0, 2'd2, 2'd0);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      expect_out("clear_ignored", 0, 1, 1, 0, 1, 0, 2'd2, 2'd0);
      OCA = 1'b0;
      step(2);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      expect_out("clear_ok", 0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
      step(1);
      expect_out("rerun", 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);

      OCA = 1'b1; OCB = 1'b1;
      step(2);
      OCA = 1'b0; OCB = 1'b0;
      step(2);
      expect_out("dual_trip", 0, 0, 1, 1, 0, 0, 2'd1, 2'd1);
      step(3);
      reset = 1'b1;
      step(1);
      expect_out("reset_cool", 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      reset = 1'b0;
      step(1);
      expect_out("post_reset_run", 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
      step(6);
      expect_out("no_retrip", 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
      run_a = 1'b0;
      step(1);
      expect_out("run_off", 0, 1, 0, 0, 0, 0, 2'd0, 2'd0);

      @(negedge clk);
      #1;
      if (total != 22) begin
         bad = bad + 1;
         $display("FAIL count: checked %0d expectations, expected 22", total);
      end
      if (bad == 0) $display("PASS");
      else          $display("FAIL: %0d mismatches", bad);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
